// File: rtl/ifu_pkg.sv
// Shared types, opcode constants and opcode classification helpers for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_IMM,
        ISSUE
    } ifu_state_t;

    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_LDI  = 4'hE;
    localparam logic [3:0] OP_JMPI = 4'hF;

    // Opcodes followed by an immediate word in memory.
    function automatic logic is_two_word(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMPI);
    endfunction

    function automatic logic is_flow(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP) || is_two_word(op);
    endfunction

endpackage

// File: rtl/ifu_pc_sel.sv
// Next-PC select: flow-control opcodes take the consumer's target, everything else falls through.
module ifu_pc_sel
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] ir_pc,
    input  logic [ADDR_W-1:0] next_ip,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = is_flow(op) ? next_ip : ir_pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, req/ack memory fetch of opcode and optional immediate, valid/ready issue.
// Define IFU_PERF_EN to add the instr_cnt/stall_cnt performance counter ports.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_imm,
    input  logic [ADDR_W-1:0] next_ip
`ifdef IFU_PERF_EN
    ,
    output logic [15:0]       instr_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    ifu_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [3:0]        rdata_op;
    logic              ack_seen;
    logic              accept;

    assign rdata_op = mem_rdata[DATA_W-1 -: 4];
    assign ack_seen = mem_req && mem_ack;
    assign accept   = ir_valid && ir_ready;

    ifu_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_sel (
        .op      (ir_opcode[DATA_W-1 -: 4]),
        .ir_pc   (ir_pc),
        .next_ip (next_ip),
        .next_pc (next_pc)
    );

    always_comb begin
        mem_addr = (state == FETCH_IMM) ? pc + ADDR_W'(1) : pc;
    end

    // A fetch state raises mem_req one cycle after entry; dropping it on ack leaves an idle cycle between fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_OP;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            ir_valid  <= 1'b0;
            ir_pc     <= '0;
            ir_opcode <= '0;
            ir_imm    <= '0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (ack_seen) begin
                        mem_req   <= 1'b0;
                        ir_opcode <= mem_rdata;
                        ir_pc     <= pc;
                        if (is_two_word(rdata_op)) begin
                            state <= FETCH_IMM;
                        end else begin
                            ir_imm   <= '0;
                            ir_valid <= 1'b1;
                            state    <= ISSUE;
                        end
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                FETCH_IMM: begin
                    if (ack_seen) begin
                        mem_req  <= 1'b0;
                        ir_imm   <= mem_rdata;
                        ir_valid <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        ir_valid <= 1'b0;
                        pc       <= next_pc;
                        state    <= FETCH_OP;
                    end
                end
                default: begin
                    state   <= FETCH_OP;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                instr_cnt <= instr_cnt + 16'd1;
            end
            if (ir_valid && !ir_ready) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: instruction table plus reset/stray-ack sequences, bundle scoreboard.
module tb_instr_fetch_unit;

    typedef struct {
        logic [15:0] op;
        logic [15:0] imm;
        logic [15:0] next_ip;
        int          hold;
        bit          stray;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] op;
        logic [15:0] imm;
    } bundle_t;

    localparam int NVEC = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] ir_pc;
    logic [15:0] ir_opcode;
    logic [15:0] ir_imm;
    logic [15:0] next_ip = 16'h0000;
`ifdef IFU_PERF_EN
    logic [15:0] instr_cnt;
    logic [15:0] stall_cnt;
`endif

    logic [15:0] mem [0:65535];
    vec_t        vecs [NVEC];
    bundle_t     exp_q [$];
    logic [15:0] exp_fetch_q [$];
    logic [15:0] fetch_q [$];
    int          fetch_rd = 0;
    bit          mem_en = 1'b0;
    int          stray_req_cnt = 0;
    int          stray_done_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    int          inst_done = 0;
    int          stall_sum = 0;

    instr_fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_pc     (ir_pc),
        .ir_opcode (ir_opcode),
        .ir_imm    (ir_imm),
        .next_ip   (next_ip)
`ifdef IFU_PERF_EN
        ,
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle ack pulses, plus injected stray acks while no request is pending.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stray_req_cnt != stray_done_cnt) begin
                stray_done_cnt = stray_done_cnt + 1;
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (mem_en && mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                fetch_q.push_back(mem_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit model_two_word(input logic [15:0] op);
        return op[15:12] >= 4'hE;
    endfunction

    function automatic logic [15:0] model_next(input vec_t v, input logic [15:0] addr);
        return (v.op[15:12] >= 4'hC) ? v.next_ip : addr + 16'd1;
    endfunction

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic [15:0] addr);
        bundle_t b;
        mem[addr] = v.op;
        b.pc  = addr;
        b.op  = v.op;
        b.imm = 16'h0000;
        exp_fetch_q.push_back(addr);
        if (model_two_word(v.op)) begin
            mem[addr + 16'd1] = v.imm;
            b.imm = v.imm;
            exp_fetch_q.push_back(addr + 16'd1);
        end
        exp_q.push_back(b);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        bundle_t b;
        bit      seen;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = ir_valid;
        end
        b = exp_q.pop_front();
        if (!seen) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL bundle_timeout[%0d]: got no ir_valid expected bundle pc %h", idx, b.pc);
        end
        compare($sformatf("ir_pc[%0d]", idx), ir_pc, b.pc);
        compare($sformatf("ir_opcode[%0d]", idx), ir_opcode, b.op);
        compare($sformatf("ir_imm[%0d]", idx), ir_imm, b.imm);
        compare($sformatf("fetch_count[%0d]", idx), 16'(fetch_q.size() - fetch_rd), 16'(exp_fetch_q.size()));
        while (exp_fetch_q.size() > 0 && fetch_rd < fetch_q.size()) begin
            compare($sformatf("fetch_addr[%0d]", idx), fetch_q[fetch_rd], exp_fetch_q.pop_front());
            fetch_rd = fetch_rd + 1;
        end
        exp_fetch_q.delete();
        fetch_rd = fetch_q.size();
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            #1;
            compare($sformatf("hold_valid[%0d]", idx), 16'(ir_valid), 16'h0001);
            compare($sformatf("hold_req[%0d]", idx), 16'(mem_req), 16'h0000);
            compare($sformatf("hold_op[%0d]", idx), ir_opcode, b.op);
            compare($sformatf("hold_imm[%0d]", idx), ir_imm, b.imm);
        end
        stall_sum = stall_sum + v.hold;
    endtask

    task automatic acceptBundle(input vec_t v, input int idx);
        next_ip  = v.next_ip;
        ir_ready = 1'b1;
        if (v.stray) begin
            stray_req_cnt = stray_req_cnt + 1;
        end
        @(negedge clk);
        #1;
        ir_ready  = 1'b0;
        next_ip   = 16'h5A5A;
        inst_done = inst_done + 1;
        compare($sformatf("valid_drop[%0d]", idx), 16'(ir_valid), 16'h0000);
`ifdef IFU_PERF_EN
        compare($sformatf("instr_cnt[%0d]", idx), instr_cnt, 16'(inst_done));
        compare($sformatf("stall_cnt[%0d]", idx), stall_cnt, 16'(stall_sum));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        compare({tag, "_mem_req"}, 16'(mem_req), 16'h0000);
        compare({tag, "_ir_valid"}, 16'(ir_valid), 16'h0000);
        compare({tag, "_mem_addr"}, mem_addr, 16'h0000);
        compare({tag, "_ir_pc"}, ir_pc, 16'h0000);
        compare({tag, "_ir_opcode"}, ir_opcode, 16'h0000);
        compare({tag, "_ir_imm"}, ir_imm, 16'h0000);
`ifdef IFU_PERF_EN
        compare({tag, "_instr_cnt"}, instr_cnt, 16'h0000);
        compare({tag, "_stall_cnt"}, stall_cnt, 16'h0000);
`endif
    endtask

    initial begin
        logic [15:0] addr;
        logic [15:0] nxt;
        vec_t        rvec;
        bit          got;

        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'h0000;
        end

        vecs[0] = '{op: 16'h1234, imm: 16'h0000, next_ip: 16'h0000, hold: 7, stray: 1'b0};
        vecs[1] = '{op: 16'h5678, imm: 16'h0000, next_ip: 16'h0000, hold: 0, stray: 1'b0};
        vecs[2] = '{op: 16'hC001, imm: 16'h0000, next_ip: 16'h0004, hold: 1, stray: 1'b0};
        vecs[3] = '{op: 16'hE000, imm: 16'hBEEF, next_ip: 16'h0040, hold: 2, stray: 1'b0};
        vecs[4] = '{op: 16'hD000, imm: 16'h0000, next_ip: 16'hFFFF, hold: 0, stray: 1'b0};
        vecs[5] = '{op: 16'hF000, imm: 16'h00AA, next_ip: 16'h0010, hold: 0, stray: 1'b0};
        vecs[6] = '{op: 16'hC905, imm: 16'h0000, next_ip: 16'h0015, hold: 0, stray: 1'b1};
        vecs[7] = '{op: 16'h0ABC, imm: 16'h0000, next_ip: 16'h1234, hold: 3, stray: 1'b0};
        vecs[8] = '{op: 16'h7FFF, imm: 16'h0000, next_ip: 16'h0000, hold: 0, stray: 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        addr = 16'h0000;
        applyStimulus(vecs[0], addr);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mem_en = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            checkOutput(vecs[i], i);
            nxt = model_next(vecs[i], addr);
            if (i + 1 < NVEC) begin
                applyStimulus(vecs[i + 1], nxt);
            end
            acceptBundle(vecs[i], i);
            addr = nxt;
        end

        // Park the unit inside FETCH_IMM with its request outstanding, then reset it.
        mem[addr]         = 16'hE555;
        mem[addr + 16'd1] = 16'h1111;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            #1;
            got = (fetch_q.size() > fetch_rd);
        end
        mem_en = 1'b0;
        compare("opcode_fetch_before_reset", 16'(got), 16'h0001);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            got = mem_req;
        end
        compare("imm_req_before_reset", 16'(got), 16'h0001);
        compare("imm_addr_before_reset", mem_addr, addr + 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midfetch_reset");

        fetch_rd  = fetch_q.size();
        inst_done = 0;
        stall_sum = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        stray_req_cnt = stray_req_cnt + 1;
        mem_en = 1'b1;
        rvec = '{op: 16'h4321, imm: 16'h0000, next_ip: 16'h0000, hold: 1, stray: 1'b0};
        applyStimulus(rvec, 16'h0000);
        checkOutput(rvec, 100);
        acceptBundle(rvec, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
